led_pattern_ctrl: RTL and testbench

Sequencer for the 4-LED pattern engine. It takes debounced single-cycle UP/DOWN button pulses and selects the active pattern. It generates the step-rate tick from the system clock and advances the step index within the selected pattern's length. PATTERN and STEP drive the combinational LED decoder (bounce, shift-left and shift-right tables) directly.

---
 rtl/led_pattern_ctrl.sv | 57 +++++
 tb/tb_led_pattern_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: selects the active LED pattern and advances its step index at a prescaled rate.
module led_pattern_ctrl #(
    parameter int DIV_W = 23
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       pause_i,
    input  logic [1:0] speed_i,
    output logic [1:0] pattern_o,
    output logic [2:0] step_o,
    output logic       step_en_o,
    output logic       wrap_o
);
    logic [1:0]       pattern_q, pattern_d;
    logic [2:0]       step_q, last;
    logic [DIV_W-1:0] cnt_q, mask;
    logic             step_en_q, wrap_q, change, tick;
    always_comb begin
        pattern_d = pattern_q == 2'd3                    ? 2'd0 :
                    (up_i && !down_i)                    ? (pattern_q == 2'd2 ? 2'd0 : 2'(pattern_q + 2'd1)) :
                    (down_i && !up_i)                    ? (pattern_q == 2'd0 ? 2'd2 : 2'(pattern_q - 2'd1)) :
                    pattern_q;
        change    = pattern_d != pattern_q;
        // Low DIV_W-SPEED prescaler bits all ones marks the end of a step period.
        mask      = {DIV_W{1'b1}} >> speed_i;
        tick      = !pause_i && ((cnt_q & mask) == mask);
        last      = pattern_q == 2'd0 ? 3'd5 : 3'd3;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pattern_q <= 2'd0;
            step_q    <= 3'd0;
            cnt_q     <= '0;
            step_en_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            if (change) begin
                step_q    <= 3'd0;
                cnt_q     <= '0;
                step_en_q <= 1'b0;
                wrap_q    <= 1'b0;
            end else begin
                cnt_q     <= pause_i ? cnt_q : cnt_q + DIV_W'(1);
                step_en_q <= tick;
                wrap_q    <= tick && step_q == last;
                if (tick) step_q <= step_q == last ? 3'd0 : step_q + 3'd1;
            end
        end
    end
    assign pattern_o = pattern_q;
    assign step_o    = step_q;
    assign step_en_o = step_en_q;
    assign wrap_o    = wrap_q;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: vector table, directed corner sequences and random stimulus against a cycle-count reference model.
module tb_led_pattern_ctrl;
    localparam int DIV_W = 4;
    logic       clk_i = 1'b0, rst_ni = 1'b0, up_i = 1'b0, down_i = 1'b0, pause_i = 1'b0;
    logic [1:0] speed_i = 2'd0;
    logic [1:0] pattern_o;
    logic [2:0] step_o;
    logic       step_en_o, wrap_o;
    int errors = 0, checks = 0;
    int m_pat, m_step, m_cnt, m_en, m_wr;

    led_pattern_ctrl #(.DIV_W(DIV_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .up_i(up_i), .down_i(down_i), .pause_i(pause_i),
        .speed_i(speed_i), .pattern_o(pattern_o), .step_o(step_o), .step_en_o(step_en_o), .wrap_o(wrap_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic u;
        logic d;
        int   exp_pat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: m_cnt counts unpaused cycles since reset/change; a step ends when it completes a whole period.
    task automatic model(input logic u, input logic d, input logic p, input logic [1:0] s);
        int np, len, period;
        np     = (u && !d) ? (m_pat + 1) % 3 : (d && !u) ? (m_pat + 2) % 3 : m_pat;
        len    = m_pat == 0 ? 6 : 4;
        period = 1 << (DIV_W - s);
        if (np != m_pat) begin
            m_pat = np; m_step = 0; m_cnt = 0; m_en = 0; m_wr = 0;
        end else if (!p && (m_cnt % period) == period - 1) begin
            m_wr = (m_step == len - 1) ? 1 : 0;
            m_step = (m_step + 1) % len;
            m_en = 1;
            m_cnt++;
        end else begin
            m_en = 0; m_wr = 0;
            if (!p) m_cnt++;
        end
    endtask

    task automatic cyc(input logic u, input logic d, input logic p, input logic [1:0] s);
        up_i = u; down_i = d; pause_i = p; speed_i = s;
        @(posedge clk_i);
        model(u, d, p, s);
        #1;
        chk("pattern", int'(pattern_o), m_pat);
        chk("step", int'(step_o), m_step);
        chk("step_en", int'(step_en_o), m_en);
        chk("wrap", int'(wrap_o), m_wr);
        up_i = 1'b0; down_i = 1'b0;
    endtask

    task automatic model_reset();
        m_pat = 0; m_step = 0; m_cnt = 0; m_en = 0; m_wr = 0;
    endtask

    task automatic free_run();
        int ens, wraps;
        ens = 0; wraps = 0;
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, 2'd0);
        chk("no_advance_before_16", int'(step_o), 0);
        cyc(0, 0, 0, 2'd0);
        chk("first_advance_edge16", int'(step_o), 1);
        ens = int'(step_en_o);
        for (int i = 0; i < 80; i++) begin
            cyc(0, 0, 0, 2'd0);
            ens += int'(step_en_o);
            wraps += int'(wrap_o);
            if (wrap_o) chk("wrap_step_zero", int'(step_o), 0);
        end
        chk("free_run_step_en_count", ens, 6);
        chk("free_run_wrap_count", wraps, 1);
        chk("free_run_end_step", int'(step_o), 0);
    endtask

    initial begin
        vec_t vt[9];
        logic [2:0] held;
        vt = '{'{1'b1, 1'b0, 1}, '{1'b1, 1'b0, 2}, '{1'b1, 1'b0, 0}, '{1'b0, 1'b1, 2},
               '{1'b1, 1'b1, 2}, '{1'b0, 1'b1, 1}, '{1'b0, 1'b1, 0}, '{1'b0, 1'b1, 2},
               '{1'b1, 1'b0, 0}};
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_pattern", int'(pattern_o), 0);
        chk("reset_step", int'(step_o), 0);
        chk("reset_step_en", int'(step_en_o), 0);
        chk("reset_wrap", int'(wrap_o), 0);
        rst_ni = 1'b1;
        free_run();

        // Pattern selection table; a few idle cycles between entries move the step phase.
        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < 20; k++) cyc(0, 0, 0, 2'd0);
            cyc(vt[i].u, vt[i].d, 0, 2'd0);
            chk($sformatf("table_pattern_%0d", i), int'(pattern_o), vt[i].exp_pat);
            if (!(vt[i].u && vt[i].d)) chk($sformatf("table_step_%0d", i), int'(step_o), 0);
        end

        // Collision: UP on the tick that would advance pattern 1 from step 3.
        cyc(1, 0, 0, 2'd0);
        for (int i = 0; i < 63; i++) cyc(0, 0, 0, 2'd0);
        chk("collision_pre_step", int'(step_o), 3);
        cyc(1, 0, 0, 2'd0);
        chk("collision_pattern", int'(pattern_o), 2);
        chk("collision_step", int'(step_o), 0);
        chk("collision_step_en", int'(step_en_o), 0);
        chk("collision_wrap", int'(wrap_o), 0);

        // PAUSE with SPEED=2: period 4, remaining phase preserved across the pause.
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 2'd2);
        chk("speed2_step", int'(step_o), 1);
        held = step_o;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 2'd2);
            chk("pause_no_step_en", int'(step_en_o), 0);
        end
        chk("pause_step_frozen", int'(step_o), int'(held));
        cyc(0, 0, 0, 2'd2);
        chk("resume_phase_hold", int'(step_o), int'(held));
        cyc(0, 0, 0, 2'd2);
        chk("resume_phase_advance", int'(step_o), int'(held) + 1);
        chk("resume_step_en", int'(step_en_o), 1);
        cyc(0, 1, 1, 2'd2);
        chk("down_in_pause_pattern", int'(pattern_o), 1);
        chk("down_in_pause_step", int'(step_o), 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 2'd2);
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 2'd2);

        // Asynchronous reset between edges with STEP=4.
        cyc(0, 1, 0, 2'd0);
        for (int i = 0; i < 64; i++) cyc(0, 0, 0, 2'd0);
        chk("pre_reset_step", int'(step_o), 4);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_reset_pattern", int'(pattern_o), 0);
        chk("async_reset_step", int'(step_o), 0);
        chk("async_reset_step_en", int'(step_en_o), 0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        model_reset();
        free_run();

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(49) == 0) speed_i = 2'($urandom_range(3));
            cyc($urandom_range(15) == 0, $urandom_range(15) == 0, $urandom_range(4) == 0, speed_i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
